// File: rtl/alu_pipelined_param.sv
// Parametrised ALU with a STAGES-deep valid/ready pipeline, full flag set and tag passthrough.
// Define ALU_PIPELINED_PERF_EN to add the perf_ops / perf_stalls counters.
module alu_pipelined_param #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2,
   parameter int TAG_W  = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic [4:0]       alu_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [TAG_W-1:0] out_tag,
   output logic             zero,
   output logic             negative,
   output logic             carry,
   output logic             overflow,
   output logic             illegal_op
`ifdef ALU_PIPELINED_PERF_EN
   ,
   output logic [31:0]      perf_ops,
   output logic [31:0]      perf_stalls
`endif
);

   localparam int SHW = $clog2(WIDTH);

   logic [SHW-1:0]   shamt;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic             lt_s;
   logic             lt_u;
   logic [WIDTH-1:0] res_c;
   logic             carry_c;
   logic             ovf_c;
   logic             ill_c;
   logic             zero_c;
   logic             neg_c;

   assign shamt = operand_b[SHW-1:0];
   assign sum   = {1'b0, operand_a} + {1'b0, operand_b};
   assign diff  = {1'b0, operand_a} + {1'b0, ~operand_b} + {{WIDTH{1'b0}}, 1'b1};
   assign lt_s  = $signed(operand_a) < $signed(operand_b);
   assign lt_u  = operand_a < operand_b;

   always_comb begin
      res_c   = '0;
      carry_c = 1'b0;
      ovf_c   = 1'b0;
      ill_c   = 1'b0;
      case (alu_op)
         5'b00000: begin
            res_c   = sum[WIDTH-1:0];
            carry_c = sum[WIDTH];
            ovf_c   = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                      (sum[WIDTH-1] != operand_a[WIDTH-1]);
         end
         5'b00001: begin
            res_c   = diff[WIDTH-1:0];
            carry_c = ~diff[WIDTH];
            ovf_c   = (operand_a[WIDTH-1] == ~operand_b[WIDTH-1]) &&
                      (diff[WIDTH-1] != operand_a[WIDTH-1]);
         end
         5'b00010: res_c = operand_a & operand_b;
         5'b00011: res_c = operand_a | operand_b;
         5'b00100: res_c = operand_a ^ operand_b;
         5'b00101: res_c = {{(WIDTH-1){1'b0}}, lt_s};
         5'b00110: res_c = operand_a << shamt;
         5'b00111: res_c = operand_a >> shamt;
         5'b01000: res_c = $signed(operand_a) >>> shamt;
         5'b01001: res_c = ~(operand_a | operand_b);
         5'b01010: res_c = {{(WIDTH-1){1'b0}}, ~lt_s};
         5'b01011: res_c = {{(WIDTH-1){1'b0}}, lt_u};
         5'b01100: res_c = {{(WIDTH-1){1'b0}}, ~lt_u};
         default:  ill_c = 1'b1;
      endcase
   end

   // An illegal op reports only illegal_op; zero stays low even though result is 0.
   assign zero_c = !ill_c && (res_c == '0);
   assign neg_c  = res_c[WIDTH-1];

   logic [STAGES-1:0] vld;
   logic [STAGES:0]   rdy;
   logic [WIDTH-1:0]  res_q [STAGES];
   logic [4:0]        flg_q [STAGES];
   logic [TAG_W-1:0]  tag_q [STAGES];

   // Ready ripples back from the consumer so empty stages absorb bubbles.
   always_comb begin
      rdy         = '0;
      rdy[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         rdy[k] = !vld[k] || rdy[k+1];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         vld <= '0;
         for (int k = 0; k < STAGES; k++) begin
            res_q[k] <= '0;
            flg_q[k] <= '0;
            tag_q[k] <= '0;
         end
      end else begin
         if (rdy[0]) begin
            vld[0] <= in_valid;
            if (in_valid) begin
               res_q[0] <= res_c;
               flg_q[0] <= {ill_c, ovf_c, carry_c, neg_c, zero_c};
               tag_q[0] <= in_tag;
            end
         end
         for (int k = 1; k < STAGES; k++) begin
            if (rdy[k]) begin
               vld[k] <= vld[k-1];
               if (vld[k-1]) begin
                  res_q[k] <= res_q[k-1];
                  flg_q[k] <= flg_q[k-1];
                  tag_q[k] <= tag_q[k-1];
               end
            end
         end
      end
   end

   assign in_ready   = rdy[0];
   assign out_valid  = vld[STAGES-1];
   assign result     = res_q[STAGES-1];
   assign out_tag    = tag_q[STAGES-1];
   assign zero       = flg_q[STAGES-1][0];
   assign negative   = flg_q[STAGES-1][1];
   assign carry      = flg_q[STAGES-1][2];
   assign overflow   = flg_q[STAGES-1][3];
   assign illegal_op = flg_q[STAGES-1][4];

`ifdef ALU_PIPELINED_PERF_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         perf_ops    <= '0;
         perf_stalls <= '0;
      end else begin
         if (out_valid && out_ready) perf_ops <= perf_ops + 32'd1;
         if (out_valid && !out_ready) perf_stalls <= perf_stalls + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_pipelined_param.sv
// Directed self-checking bench for alu_pipelined_param (WIDTH=32, STAGES=2, TAG_W=4).
module tb_alu_pipelined_param;

   localparam int WIDTH  = 32;
   localparam int STAGES = 2;
   localparam int TAG_W  = 4;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic [4:0]       alu_op;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [TAG_W-1:0] out_tag;
   logic             zero;
   logic             negative;
   logic             carry;
   logic             overflow;
   logic             illegal_op;
`ifdef ALU_PIPELINED_PERF_EN
   logic [31:0]      perf_ops;
   logic [31:0]      perf_stalls;
`endif

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   alu_pipelined_param #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .operand_a(operand_a),
      .operand_b(operand_b),
      .alu_op(alu_op),
      .in_tag(in_tag),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result(result),
      .out_tag(out_tag),
      .zero(zero),
      .negative(negative),
      .carry(carry),
      .overflow(overflow),
      .illegal_op(illegal_op)
`ifdef ALU_PIPELINED_PERF_EN
      ,
      .perf_ops(perf_ops),
      .perf_stalls(perf_stalls)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
      end
   endtask

   task automatic setOp(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op, input logic [3:0] tag);
      operand_a = a;
      operand_b = b;
      alu_op    = op;
      in_tag    = tag;
   endtask

   // One op in, then wait STAGES edges so the result sits at the output.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op, input logic [3:0] tag);
      setOp(a, b, op, tag);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 1; i < STAGES; i++) step();
   endtask

   task automatic doReset();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   initial begin
      int next_in;
      int got;
      int cycles;
      logic tin;
      logic tout;

      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      setOp(32'd0, 32'd0, 5'd0, 4'd0);
      doReset();
      step(); step(); step();
      checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
      checkOutput("reset_result", {32'd0, result}, 64'd0);
      checkOutput("reset_flags", {59'd0, illegal_op, overflow, carry, negative, zero}, 64'd0);
      checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);

      applyStimulus(32'h7FFF_FFFF, 32'd1, 5'b00000, 4'd3);
      checkOutput("add_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("add_result", {32'd0, result}, 64'h8000_0000);
      checkOutput("add_overflow", {63'd0, overflow}, 64'd1);
      checkOutput("add_negative", {63'd0, negative}, 64'd1);
      checkOutput("add_carry", {63'd0, carry}, 64'd0);
      checkOutput("add_zero", {63'd0, zero}, 64'd0);
      checkOutput("add_tag", {60'd0, out_tag}, 64'd3);
      step();

      setOp(32'd5, 32'd5, 5'b00001, 4'd1);
      in_valid = 1'b1;
      step();
      setOp(32'd1, 32'd2, 5'b00001, 4'd2);
      step();
      in_valid = 1'b0;
      checkOutput("sub1_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("sub1_result", {32'd0, result}, 64'd0);
      checkOutput("sub1_zero", {63'd0, zero}, 64'd1);
      checkOutput("sub1_carry", {63'd0, carry}, 64'd0);
      checkOutput("sub1_tag", {60'd0, out_tag}, 64'd1);
      step();
      checkOutput("sub2_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("sub2_result", {32'd0, result}, 64'hFFFF_FFFF);
      checkOutput("sub2_carry", {63'd0, carry}, 64'd1);
      checkOutput("sub2_negative", {63'd0, negative}, 64'd1);
      checkOutput("sub2_overflow", {63'd0, overflow}, 64'd0);
      checkOutput("sub2_tag", {60'd0, out_tag}, 64'd2);
      step();
      checkOutput("sub_drained", {63'd0, out_valid}, 64'd0);

      // Six ADDs: op i computes (10i+3)+i = 11i+3 with tag 8+i.
      out_ready = 1'b0;
      next_in   = 0;
      for (int c = 0; c < 4; c++) begin
         setOp(32'(10 * next_in + 3), 32'(next_in), 5'b00000, 4'(8 + next_in));
         in_valid = 1'b1;
         #1;
         tin = in_ready;
         if (c >= 2) begin
            checkOutput($sformatf("stall_in_ready_%0d", c), {63'd0, in_ready}, 64'd0);
            checkOutput($sformatf("stall_valid_%0d", c), {63'd0, out_valid}, 64'd1);
            checkOutput($sformatf("stall_hold_result_%0d", c), {32'd0, result}, 64'd3);
            checkOutput($sformatf("stall_hold_tag_%0d", c), {60'd0, out_tag}, 64'd8);
         end
         step();
         if (tin) next_in++;
      end
      out_ready = 1'b1;
      #1;
      checkOutput("release_in_ready", {63'd0, in_ready}, 64'd1);
      got    = 0;
      cycles = 0;
      while (got < 6 && cycles < 30) begin
         if (next_in < 6) begin
            setOp(32'(10 * next_in + 3), 32'(next_in), 5'b00000, 4'(8 + next_in));
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         tin  = in_valid && in_ready;
         tout = out_valid && out_ready;
         if (tout) begin
            checkOutput($sformatf("stream_result_%0d", got), {32'd0, result}, 64'(11 * got + 3));
            checkOutput($sformatf("stream_tag_%0d", got), {60'd0, out_tag}, 64'(8 + got));
            got++;
         end
         step();
         if (tin) next_in++;
         cycles++;
      end
      in_valid = 1'b0;
      checkOutput("stream_count", 64'(got), 64'd6);
      checkOutput("stream_cycles", 64'(cycles), 64'd6);
      step();
      checkOutput("stream_drained", {63'd0, out_valid}, 64'd0);

      applyStimulus(32'h8000_0000, 32'h0000_0021, 5'b01000, 4'd6);
      checkOutput("sra_result", {32'd0, result}, 64'hC000_0000);
      checkOutput("sra_negative", {63'd0, negative}, 64'd1);
      step();
      applyStimulus(32'h1234_5678, 32'h0000_0001, 5'b11111, 4'd7);
      checkOutput("illegal_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("illegal_result", {32'd0, result}, 64'd0);
      checkOutput("illegal_flag", {63'd0, illegal_op}, 64'd1);
      checkOutput("illegal_other_flags", {60'd0, overflow, carry, negative, zero}, 64'd0);
      step();

      // Two ops parked in the pipe, then a one-cycle reset discards them.
      out_ready = 1'b0;
      setOp(32'd10, 32'd20, 5'b00000, 4'd9);
      in_valid = 1'b1;
      step();
      setOp(32'd30, 32'd40, 5'b00000, 4'd10);
      step();
      in_valid = 1'b0;
      reset_n  = 1'b0;
      step();
      reset_n   = 1'b1;
      out_ready = 1'b1;
      checkOutput("midreset_valid", {63'd0, out_valid}, 64'd0);
      checkOutput("midreset_result", {32'd0, result}, 64'd0);
      step();
      checkOutput("midreset_valid_later", {63'd0, out_valid}, 64'd0);
      setOp(32'd2, 32'd3, 5'b00000, 4'd5);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      checkOutput("postreset_lat1", {63'd0, out_valid}, 64'd0);
      step();
      checkOutput("postreset_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("postreset_result", {32'd0, result}, 64'd5);
      checkOutput("postreset_tag", {60'd0, out_tag}, 64'd5);
      step();

`ifdef ALU_PIPELINED_PERF_EN
      doReset();
      out_ready = 1'b0;
      setOp(32'd1, 32'd1, 5'b00000, 4'd1);
      in_valid = 1'b1;
      step();
      setOp(32'd2, 32'd2, 5'b00000, 4'd2);
      step();
      in_valid = 1'b0;
      step(); step(); step();
      out_ready = 1'b1;
      step(); step();
      applyStimulus(32'd3, 32'd3, 5'b00000, 4'd3);
      applyStimulus(32'd4, 32'd4, 5'b00000, 4'd4);
      step();
      checkOutput("perf_ops", {32'd0, perf_ops}, 64'd4);
      checkOutput("perf_stalls", {32'd0, perf_stalls}, 64'd3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/alu_pipelined_param.md
Name: alu_pipelined_param

Overview:
- Parametrised successor to the fixed two-stage ALU.
- Datapath width and pipeline depth are configurable, and each stage has a valid/ready handshake with backpressure.
- Full flag set (zero, negative, carry, overflow) and an illegal-op indication travel with each result, plus a user tag passthrough.
- Sits between the decode/issue logic and writeback in the RISC-V processor datapath.

Parameters:
- WIDTH, 32, operand/result width in bits; legal values 8..64, power of 2.
- STAGES, 2, pipeline depth in registers, input to output; legal 1..4.
- TAG_W, 4, width of the opaque tag carried alongside each op.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  input op valid
- in_ready  out  1  block can accept an op this cycle
- operand_a  in  WIDTH  first operand
- operand_b  in  WIDTH  second operand
- alu_op  in  5  operation code
- in_tag  in  TAG_W  user tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  final result
- out_tag  out  TAG_W  tag of this result
- zero  out  1  result == 0
- negative  out  1  result[WIDTH-1]
- carry  out  1  ADD: carry-out; SUB: borrow (a <u b); else 0
- overflow  out  1  ADD/SUB signed overflow; else 0
- illegal_op  out  1  alu_op not in the opcode list

Behaviour:
- Reset (reset_n=0 at posedge clk): all stage valids cleared. out_valid, result, out_tag and all flags are 0. in_ready is 1 from the first cycle after reset.
- Reset mid-operation: in-flight ops are discarded with no output.
- Opcodes (shamt = operand_b[$clog2(WIDTH)-1:0]):
  - 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 XOR
  - 00101 SLT (signed), 00110 SLL, 00111 SRL, 01000 SRA, 01001 NOR
  - 01010 SGE (signed), 01011 SLTU, 01100 SGEU
  - All others: result 0, all other flags 0, illegal_op=1.
- Compute: the full result and all flags are computed combinationally at input and captured into stage 1. Stages 2..STAGES are pure delay registers carrying {valid, result, flags, tag}.
- Arithmetic: ADD/SUB are computed at WIDTH+1 bits.
  - carry = bit WIDTH for ADD.
  - For SUB, carry = borrow, i.e. the inverted bit WIDTH of a + ~b + 1.
  - overflow = (a_msb==b_msb_eff) && (res_msb!=a_msb), where b_msb_eff is inverted for SUB.
  - Compares yield 1 or 0 zero-extended to WIDTH.
- Handshake:
  - Stage k can load when it is empty or its contents move on this cycle: ready_k = !valid_k || ready_{k+1}.
  - ready_{STAGES+1} = out_ready.
  - in_ready = ready_1.
  - Transfer in occurs on in_valid && in_ready; transfer out occurs on out_valid && out_ready.
- Outputs are the last stage registers. While out_valid=1 && out_ready=0, result, flags and tag hold stable.
- Latency: exactly STAGES cycles from input transfer to out_valid with no backpressure. Throughput is 1 op/cycle.
- Bubbles are compressed: an empty stage accepts even when downstream is stalled.
- Full pipeline with out_ready=0 drives in_ready=0. When out_ready rises, in_ready rises in the same cycle (combinational chain).
- Simultaneous input and output transfer with a full pipeline is legal and keeps occupancy constant.
- in_valid while in_ready=0: the op is not taken. The source must hold it; the block does not check this.
- Order is strictly FIFO. No op is dropped or duplicated.

Optional Feature:
- Macro: ALU_PIPELINED_PERF_EN.
- When defined, adds outputs perf_ops (32 bits) and perf_stalls (32 bits).
  - perf_ops increments on each output transfer.
  - perf_stalls increments each cycle in which out_valid && !out_ready.
  - Both counters are cleared by reset_n and wrap modulo 2^32.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then idle 3 cycles -> out_valid=0, result=0, all flags 0, in_ready=1.
- WIDTH=32, STAGES=2, ADD a=0x7FFFFFFF b=1, tag=3, out_ready=1 -> after 2 cycles: result=0x80000000, overflow=1, negative=1, carry=0, zero=0, out_tag=3.
- SUB a=5 b=5, then SUB a=1 b=2 back-to-back:
  - 1st result: 0, zero=1, carry=0.
  - 2nd result: 0xFFFFFFFF, carry=1, negative=1, on consecutive cycles.
- Stream 6 ops with out_ready=0:
  - in_ready drops after 2 accepts; out_valid=1 with the first result held stable.
  - When out_ready is raised, all 6 results appear in order with tags matching, with no gaps beyond the stall.
- SRA a=0x80000000 b=0x21 (shamt=1) -> 0xC0000000. Opcode 11111 -> result 0, illegal_op=1.
- Assert reset_n=0 for 1 cycle with 2 ops in flight -> no out_valid for those ops. The next op issued completes with latency STAGES.
- With ALU_PIPELINED_PERF_EN defined: 4 ops with 3 stall cycles -> perf_ops=4, perf_stalls=3.
